// File: rtl/onchip_ram_pkg.sv
// Shared defaults and types for the two-master on-chip RAM arbiter.
package onchip_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 16;

    typedef logic req_idx_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: sole requester wins, contention goes to the one not granted last.
module rr_arb2
    import onchip_ram_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (&req)
            grant = last_grant ? 2'b01 : 2'b10;
        else
            grant = req;
    end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Arbitrates two Avalon-style masters onto one single-port on-chip RAM with fixed read latency 1.
module onchip_ram_arbiter
    import onchip_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0]       active;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             any_grant;
    req_idx_t         sel;
    req_idx_t         last_grant;
    logic             rsp_valid;
    req_idx_t         rsp_owner;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    assign active = {m1_read | m1_write, m0_read | m0_write};
    // Requests are masked during reset so nothing reaches the RAM or the response pipe.
    assign req    = active & {2{reset_n}};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign any_grant = |grant;
    assign sel       = grant[1];

    always_comb begin
        ram_address    = sel ? m1_address    : m0_address;
        ram_byteenable = sel ? m1_byteenable : m0_byteenable;
        ram_writedata  = sel ? m1_writedata  : m0_writedata;
        ram_chipselect = any_grant;
        ram_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
        ram_clken      = 1'b1;
    end

    always_comb begin
        m0_waitrequest   = ~reset_n | (active[0] & ~grant[0]);
        m1_waitrequest   = ~reset_n | (active[1] & ~grant[1]);
        m0_readdata      = ram_readdata;
        m1_readdata      = ram_readdata;
        m0_readdatavalid = reset_n & rsp_valid & (rsp_owner == 1'b0);
        m1_readdatavalid = reset_n & rsp_valid & (rsp_owner == 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_owner  <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (any_grant)
                last_grant <= sel;
            rsp_valid <= any_grant & ~ram_write;
            rsp_owner <= sel;
            if (grant[0])
                grant_cnt0 <= sat_inc(grant_cnt0);
            if (grant[1])
                grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_onchip_ram_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_readdata;

    logic [DW-1:0] mem [0:8191];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    // Single-port RAM model: byte-lane writes, registered read, plus a preload port.
    always @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b])
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        load_en = 1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0; load_en = 0; load_addr = '0; load_data = '0;
        idle_all();
        m0_address = '0; m1_address = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;
        preload(13'h0010, 32'hDEADBEEF);
        preload(13'h0020, 32'h11112222);
        preload(13'h1FFF, 32'hAAAAAAAA);

        // Reset-state outputs with requests pending
        @(negedge clk);
        m0_read = 1; m1_read = 1;
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_wr", ram_write, 0);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk);
        idle_all(); reset_n = 1;
        #1;
        chk("rst_cnt0", 32'(dut.grant_cnt0), 0);
        chk("rst_cnt1", 32'(dut.grant_cnt1), 0);
        chk("idle_m0_wait", m0_waitrequest, 0);
        chk("idle_cs", ram_chipselect, 0);

        // Single read
        @(negedge clk);
        m0_read = 1; m0_address = 13'h0010;
        #1;
        chk("sr_m0_wait", m0_waitrequest, 0);
        chk("sr_cs", ram_chipselect, 1);
        chk("sr_addr", 32'(ram_address), 32'h10);
        chk("sr_wr", ram_write, 0);
        @(negedge clk);
        idle_all();
        #1;
        chk("sr_m0_rdv", m0_readdatavalid, 1);
        chk("sr_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("sr_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk);
        #1;
        chk("sr_m0_rdv_once", m0_readdatavalid, 0);

        // Contention right after reset
        do_reset();
        m0_read = 1; m0_address = 13'h0010;
        m1_read = 1; m1_address = 13'h0020;
        #1;
        chk("ct_m0_wait", m0_waitrequest, 0);
        chk("ct_m1_wait", m1_waitrequest, 1);
        @(negedge clk);
        m0_read = 0;
        #1;
        chk("ct_m1_wait2", m1_waitrequest, 0);
        chk("ct_addr2", 32'(ram_address), 32'h20);
        chk("ct_m0_rdv", m0_readdatavalid, 1);
        chk("ct_m0_data", m0_readdata, 32'hDEADBEEF);
        @(negedge clk);
        idle_all();
        #1;
        chk("ct_m1_rdv", m1_readdatavalid, 1);
        chk("ct_m1_data", m1_readdata, 32'h11112222);
        chk("ct_m0_rdv2", m0_readdatavalid, 0);

        // Sustained contention for 8 cycles
        do_reset();
        m0_read = 1; m1_read = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("ss_m0_wait", m0_waitrequest, (i % 2 == 1));
            chk("ss_m1_wait", m1_waitrequest, (i % 2 == 0));
            if (i > 0) begin
                chk("ss_m0_rdv", m0_readdatavalid, ((i - 1) % 2 == 0));
                chk("ss_m1_rdv", m1_readdatavalid, ((i - 1) % 2 == 1));
                chk("ss_data", m0_readdata, ((i - 1) % 2 == 0) ? 32'hDEADBEEF : 32'h11112222);
            end
        end
        @(negedge clk);
        idle_all();
        #1;
        chk("ss_last_m1_rdv", m1_readdatavalid, 1);
        chk("ss_cnt0", 32'(dut.grant_cnt0), 4);
        chk("ss_cnt1", 32'(dut.grant_cnt1), 4);

        // Write then read with partial byteenable at the top address
        @(negedge clk);
        m1_write = 1; m1_address = 13'h1FFF; m1_byteenable = 4'h3; m1_writedata = 32'h12345678;
        #1;
        chk("wr_m1_wait", m1_waitrequest, 0);
        chk("wr_ram_wr", ram_write, 1);
        chk("wr_be", 32'(ram_byteenable), 32'h3);
        chk("wr_wdata", ram_writedata, 32'h12345678);
        @(negedge clk);
        idle_all();
        m0_read = 1; m0_address = 13'h1FFF;
        #1;
        chk("wr_m0_wait", m0_waitrequest, 0);
        chk("wr_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk);
        idle_all();
        #1;
        chk("wr_m0_rdv", m0_readdatavalid, 1);
        chk("wr_m0_data", m0_readdata, 32'hAAAA5678);

        // Reset asserted in the cycle m1's read would be granted
        @(negedge clk);
        m0_read = 1; m0_address = 13'h0010;
        #1;
        chk("rm_m0_wait", m0_waitrequest, 0);
        @(negedge clk);
        m0_read = 0; m1_read = 1; m1_address = 13'h0020; reset_n = 0;
        #1;
        chk("rm_m1_wait", m1_waitrequest, 1);
        chk("rm_cs", ram_chipselect, 0);
        chk("rm_m0_rdv", m0_readdatavalid, 0);
        @(negedge clk);
        idle_all(); reset_n = 1;
        #1;
        chk("rm_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk);
        #1;
        chk("rm_m1_rdv2", m1_readdatavalid, 0);
        @(negedge clk);
        m0_read = 1; m1_read = 1;
        #1;
        chk("rm_ct_m0_wait", m0_waitrequest, 0);
        chk("rm_ct_m1_wait", m1_waitrequest, 1);
        @(negedge clk);
        m0_read = 0;
        #1;
        chk("rm_ct_m1_wait2", m1_waitrequest, 0);
        @(negedge clk);
        idle_all();

        // Read and write together acts as a write
        @(negedge clk);
        m0_read = 1; m0_write = 1; m0_address = 13'h0030; m0_byteenable = 4'hF; m0_writedata = 32'hCAFEF00D;
        #1;
        chk("rw_m0_wait", m0_waitrequest, 0);
        chk("rw_ram_wr", ram_write, 1);
        @(negedge clk);
        idle_all();
        m1_read = 1; m1_address = 13'h0030; m1_byteenable = 4'hF;
        #1;
        chk("rw_m0_rdv", m0_readdatavalid, 0);
        chk("rw_mem", mem[13'h0030], 32'hCAFEF00D);
        @(negedge clk);
        idle_all();
        #1;
        chk("rw_m1_rdv", m1_readdatavalid, 1);
        chk("rw_m1_data", m1_readdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/onchip_ram_arbiter.md
ONCHIP_RAM_ARBITER -- requirements
Module: onchip_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning RAM word-address width (8192 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have, for each requester N in {0,1}, the following ports:
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_address  in  ADDR_W  word address.
- mN_byteenable  in  DATA_W/8  byte lanes.
- mN_writedata  in  DATA_W  write data.
- mN_waitrequest  out  1  high = request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  one-cycle read-response strobe.
REQ-006 SHALL have RAM-side port ram_address  out  ADDR_W  RAM address.
REQ-007 SHALL have RAM-side port ram_byteenable  out  DATA_W/8  RAM byte lanes.
REQ-008 SHALL have RAM-side port ram_chipselect  out  1  RAM select.
REQ-009 SHALL have RAM-side port ram_write  out  1  RAM write.
REQ-010 SHALL have RAM-side port ram_writedata  out  DATA_W  RAM write data.
REQ-011 SHALL have RAM-side port ram_clken  out  1  RAM clock enable, tied high.
REQ-012 SHALL have RAM-side port ram_readdata  in  DATA_W  RAM read data, valid one cycle after a read is presented.

Function
REQ-013 SHALL treat a requester as active when mN_read|mN_write; mN_read&mN_write together is treated as a write.
REQ-014 SHALL grant at most one requester per cycle, combinationally from the current requests and the registered last_grant bit.
REQ-015 SHALL grant the sole active requester immediately; with both active it SHALL grant the requester != last_grant (round-robin).
REQ-016 SHALL drive mN_waitrequest = active_N & ~grant_N; an idle requester sees waitrequest low.
REQ-017 SHALL route the granted requester's address, byteenable and writedata to the RAM with ram_chipselect=1 in the grant cycle; ram_write=1 only for a granted write.
REQ-018 SHALL drive ram_chipselect=0 and ram_write=0 when there is no grant.
REQ-019 SHALL update last_grant to the granted index on every grant cycle and hold it otherwise.
REQ-020 SHALL register rsp_valid and rsp_owner for a granted read, then in the next cycle assert m<rsp_owner>_readdatavalid for exactly one cycle with readdata = ram_readdata (fixed latency 1).
REQ-021 SHALL drive mN_readdata from ram_readdata to both requesters; only readdatavalid is qualified.
REQ-022 SHALL sustain back-to-back reads from alternating requesters at one read per cycle with responses in grant order.
REQ-023 SHALL keep a write's side effects visible to a read granted in the following cycle (no write buffering).
REQ-024 SHALL keep a 16-bit grant counter per requester that saturates at 0xFFFF, exposed only for verification through hierarchical access.

Reset
REQ-025 SHALL, while reset_n=0 at a clock edge, set last_grant=1 so that requester 0 wins the first contention, and clear rsp_valid, rsp_owner and both counters.
REQ-026 SHALL keep outputs during reset as: mN_waitrequest=1, mN_readdatavalid=0, ram_chipselect=0, ram_write=0.
REQ-027 SHALL not issue a readdatavalid after reset for a read granted in the cycle in which reset was asserted.

Structure
REQ-028 SHALL take ADDR_W/DATA_W defaults and the requester-index type (1 bit) from shared package onchip_ram_pkg.
REQ-029 SHALL be a single module with one natural sub-module, rr_arb2 (2-way round-robin grant logic: requests and last_grant in, one-hot grant out).

Verification
REQ-030 Single read: m0 reads addr 0x0010 holding 0xDEADBEEF -> m0_waitrequest=0 in cycle T, m0_readdatavalid=1 with 0xDEADBEEF at T+1.
REQ-031 Contention after reset: m0 and m1 both read in cycle T -> m0 granted at T, m1 at T+1, valids at T+1 (m0) and T+2 (m1).
REQ-032 Sustained contention: both requesters issue continuous reads for 8 cycles -> grants alternate 0,1,0,1...; each counter = 4.
REQ-033 Write then read: m1 writes 0x12345678 with byteenable 0x3 to addr 0x1FFF (preset 0xAAAAAAAA), then m0 reads addr 0x1FFF next cycle -> m0 gets 0xAAAA5678.
REQ-034 Reset mid-operation: reset_n low in the cycle m1's read is granted -> no m1_readdatavalid afterwards; next contention grants m0 first.
REQ-035 Read and write together: m0 asserts read=1 and write=1 -> RAM write performed, no readdatavalid.
